// File: rtl/unary_decoder.sv
// Unary (thermometer) stream decoder: counts the '1' bits of a STREAM_LEN-bit
// serial frame, flags ones that arrive after a zero, and pulses done with the result.
module unary_decoder #(
    parameter int STREAM_LEN = 16,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] value_out,
    output logic             code_err
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(STREAM_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [CNT_W-1:0] ones_cnt_r;
    logic             seen_zero_r;
    logic             err_r;

    logic             last_bit_s;
    logic [CNT_W-1:0] ones_next_s;
    logic             err_next_s;

    // Counter and error values that include the bit currently on bit_in
    always_comb begin
        last_bit_s  = (bit_cnt_r == LAST_IDX);
        ones_next_s = ones_cnt_r + {{(CNT_W-1){1'b0}}, bit_in};
        if (seen_zero_r && bit_in) begin
            err_next_s = 1'b1;
        end else begin
            err_next_s = err_r;
        end
    end

    // Frame collection FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            bit_cnt_r   <= CNT_ZERO;
            ones_cnt_r  <= CNT_ZERO;
            seen_zero_r <= 1'b0;
            err_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            value_out   <= CNT_ZERO;
            code_err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r     <= COLLECT;
                        bit_cnt_r   <= CNT_ZERO;
                        ones_cnt_r  <= CNT_ZERO;
                        seen_zero_r <= 1'b0;
                        err_r       <= 1'b0;
                        busy        <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                COLLECT: begin
                    // A restart wins over any bit presented in the same cycle
                    if (start) begin
                        bit_cnt_r   <= CNT_ZERO;
                        ones_cnt_r  <= CNT_ZERO;
                        seen_zero_r <= 1'b0;
                        err_r       <= 1'b0;
                        busy        <= 1'b1;
                    end else if (bit_valid) begin
                        if (last_bit_s) begin
                            state_r   <= IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            value_out <= ones_next_s;
                            code_err  <= err_next_s;
                        end else begin
                            busy <= 1'b1;
                        end
                        bit_cnt_r   <= bit_cnt_r + CNT_ONE;
                        ones_cnt_r  <= ones_next_s;
                        seen_zero_r <= seen_zero_r | ~bit_in;
                        err_r       <= err_next_s;
                    end else begin
                        busy <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unary_decoder.sv
// Scoreboard bench for unary_decoder: stimulus queues expected results with
// their arrival cycle; a monitor checks every done pulse against the queue.
module tb_unary_decoder;

    logic       clk;
    logic       rst;
    logic       start;
    logic       bit_valid;
    logic       bit_in;
    logic       busy;
    logic       done;
    logic [5:0] value_out;
    logic       code_err;

    typedef struct {
        logic [5:0] val;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    int   cyc;

    unary_decoder #(.STREAM_LEN(16), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .busy      (busy),
        .done      (done),
        .value_out (value_out),
        .code_err  (code_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("value_out", int'(value_out), int'(e.val));
                check("code_err", int'(code_err), int'(e.err));
                check("done_cycle", cyc, e.cyc);
                check("busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic drive(input logic s, input logic v, input logic b);
        @(posedge clk);
        #1;
        start     = s;
        bit_valid = v;
        bit_in    = b;
    endtask

    // Start a frame and stream its 16 bits (bits[0] first), optionally with gaps
    task automatic run_frame(input logic [15:0] bits, input int gap_len,
                             input logic [5:0] ev, input logic ee, input string tag);
        exp_t e;
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, bits[i]);
            if (i == 0) check({tag, "_busy"}, int'(busy), 1);
            if (gap_len > 0 && (i % 4) == 3 && i < 15) begin
                for (int g = 0; g < gap_len; g++) drive(1'b0, 1'b0, 1'b0);
            end
        end
        e.val = ev;
        e.err = ee;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst       = 1'b1;
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_value", int'(value_out), 0);
        check("rst_err", int'(code_err), 0);
        rst = 1'b0;

        // bit_valid in IDLE is ignored: no done may appear
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check("idle_busy", int'(busy), 0);

        run_frame(16'h0000, 0, 6'd0, 1'b0, "zeros");
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        // back-to-back frames: each start lands in the done cycle of the previous
        run_frame(16'h001F, 0, 6'd5, 1'b0, "five");
        run_frame(16'hFFFF, 0, 6'd16, 1'b0, "full");
        run_frame(16'h000B, 0, 6'd3, 1'b1, "bad");
        run_frame(16'h007F, 0, 6'd7, 1'b0, "seven");
        drive(1'b0, 1'b0, 1'b0);
        run_frame(16'h03FF, 3, 6'd10, 1'b0, "gaps");
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // Abort: 8 ones, restart with a discarded bit, then 2 ones + 14 zeros
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        check("abort_hold_value", int'(value_out), 10);
        check("abort_busy", int'(busy), 1);
        drive(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            if (i == 13) begin
                exp_t e;
                e.val = 6'd2;
                e.err = 1'b0;
                e.cyc = cyc + 1;
                exp_q.push_back(e);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("abort_value", int'(value_out), 2);

        // Reset mid-frame: frame discarded, outputs back to reset values
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_value", int'(value_out), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("midrst_value_later", int'(value_out), 0);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
